// File: rtl/hw_reg_pkg.sv
// Shared constants and FSM encoding for the serial display-register receiver.
package hw_reg_pkg;

    localparam int REG_SIZE_DEF     = 8;
    localparam int NUM_DATA_REG_DEF = 6;
    localparam int SYNC_DEPTH       = 2;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/hw_registers_receiver_sync_edge_detect.sv
// Two-flop synchronizer for one strobe pin with a registered rising-edge pulse;
// the pulse appears three clk edges after the pin rises.
module sync_edge_detect
    import hw_reg_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [SYNC_DEPTH-1:0] pipe;
    logic                  last;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
            last <= 1'b0;
            rise <= 1'b0;
        end else begin
            pipe <= {pipe[SYNC_DEPTH-2:0], din};
            last <= pipe[SYNC_DEPTH-1];
            rise <= pipe[SYNC_DEPTH-1] & ~last;
        end
    end

endmodule

// File: rtl/hw_registers_receiver.sv
// Receives chained shift-register display traffic (digit select + segment data)
// and reassembles complete frames of NUM_DATA_REG digits with active-high segments.
module hw_registers_receiver
    import hw_reg_pkg::*;
#(
    parameter int REG_SIZE     = REG_SIZE_DEF,
    parameter int NUM_DATA_REG = NUM_DATA_REG_DEF
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    all_nrst,
    input  logic                                    all_bit_clk,
    input  logic                                    control_reg_clk,
    input  logic                                    control_data_ser,
    input  logic                                    digit_data_ser,
    output logic [NUM_DATA_REG-1:0][REG_SIZE-1:0]   frame_out,
    output logic                                    frame_valid,
    output logic                                    len_err,
    output logic                                    sel_err,
    output state_t                                  state
);

    localparam int                CW       = $clog2(REG_SIZE + 2);
    localparam logic [CW-1:0]     CNT_FULL = CW'(REG_SIZE);
    localparam logic [CW-1:0]     CNT_SAT  = CW'(REG_SIZE + 1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [NUM_DATA_REG-1:0] SEL_ONE = NUM_DATA_REG'(1);

    logic                                  bit_rise;
    logic                                  latch_rise;
    // Data pipes are one stage longer than the sync so the sampled bit lines up with the edge pulse.
    logic [SYNC_DEPTH:0]                   ctl_pipe;
    logic [SYNC_DEPTH:0]                   dig_pipe;
    logic [SYNC_DEPTH-1:0]                 nrst_pipe;
    logic                                  nrst_s;

    logic [REG_SIZE-1:0]                   ctl_sr;
    logic [REG_SIZE-1:0]                   dig_sr;
    logic [CW-1:0]                         bit_cnt;
    logic [NUM_DATA_REG-1:0][REG_SIZE-1:0] staging;
    logic [NUM_DATA_REG-1:0][REG_SIZE-1:0] staging_next;
    logic [NUM_DATA_REG-1:0]               seen;
    logic [NUM_DATA_REG-1:0]               seen_next;
    logic [NUM_DATA_REG-1:0]               sel_low;
    logic                                  sel_ok;
    logic                                  len_ok;
    logic                                  write_en;
    logic                                  frame_done;
    state_t                                state_next;

    sync_edge_detect u_bit_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (all_bit_clk),
        .rise (bit_rise)
    );

    sync_edge_detect u_latch_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (control_reg_clk),
        .rise (latch_rise)
    );

    assign nrst_s  = nrst_pipe[SYNC_DEPTH-1];
    assign sel_low = ctl_sr[NUM_DATA_REG-1:0];
    assign sel_ok  = ((ctl_sr >> NUM_DATA_REG) == '0) && (sel_low != '0)
                     && ((sel_low & (sel_low - SEL_ONE)) == '0);
    assign len_ok  = (bit_cnt == CNT_FULL);
    assign write_en = (state == LATCH) && len_ok && sel_ok;

    always_comb begin
        staging_next = staging;
        seen_next    = seen;
        if (write_en) begin
            for (int k = 0; k < NUM_DATA_REG; k++) begin
                if (sel_low[k]) staging_next[k] = ~dig_sr;
            end
            seen_next = seen | sel_low;
        end
    end

    assign frame_done = write_en && (&seen_next);

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (nrst_s) state_next = SHIFT;
            SHIFT:   if (latch_rise) state_next = LATCH;
            LATCH:   state_next = SHIFT;
            default: state_next = CLEAR;
        endcase
        if (!nrst_s) state_next = CLEAR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_pipe    <= '0;
            dig_pipe    <= '0;
            nrst_pipe   <= '0;
            ctl_sr      <= '0;
            dig_sr      <= '0;
            bit_cnt     <= '0;
            staging     <= '0;
            seen        <= '0;
            frame_out   <= '0;
            frame_valid <= 1'b0;
            len_err     <= 1'b0;
            sel_err     <= 1'b0;
            state       <= CLEAR;
        end else begin
            ctl_pipe    <= {ctl_pipe[SYNC_DEPTH-1:0], control_data_ser};
            dig_pipe    <= {dig_pipe[SYNC_DEPTH-1:0], digit_data_ser};
            nrst_pipe   <= {nrst_pipe[SYNC_DEPTH-2:0], all_nrst};
            state       <= state_next;
            frame_valid <= 1'b0;
            // Bus clear wipes the partial frame but keeps the last frame and sticky errors.
            if (!nrst_s || state == CLEAR) begin
                ctl_sr  <= '0;
                dig_sr  <= '0;
                bit_cnt <= '0;
                staging <= '0;
                seen    <= '0;
            end else if (state == SHIFT) begin
                if (bit_rise) begin
                    ctl_sr  <= {ctl_sr[REG_SIZE-2:0], ctl_pipe[SYNC_DEPTH]};
                    dig_sr  <= {dig_sr[REG_SIZE-2:0], dig_pipe[SYNC_DEPTH]};
                    bit_cnt <= (bit_cnt == CNT_SAT) ? bit_cnt : bit_cnt + CNT_ONE;
                end
            end else if (state == LATCH) begin
                bit_cnt <= '0;
                if (!len_ok) len_err <= 1'b1;
                if (!sel_ok) sel_err <= 1'b1;
                staging <= staging_next;
                seen    <= frame_done ? '0 : seen_next;
                if (frame_done) begin
                    frame_out   <= staging_next;
                    frame_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hw_registers_receiver.sv
// Bench for hw_registers_receiver: table of serial transfers plus hand-built
// corner sequences, with completed frames checked against an expected queue.
module tb_hw_registers_receiver;
    import hw_reg_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            all_nrst;
    logic            all_bit_clk;
    logic            control_reg_clk;
    logic            control_data_ser;
    logic            digit_data_ser;
    logic [5:0][7:0] frame_out;
    logic            frame_valid;
    logic            len_err;
    logic            sel_err;
    state_t          state;

    always #5 clk = ~clk;

    hw_registers_receiver #(.REG_SIZE(8), .NUM_DATA_REG(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .all_nrst         (all_nrst),
        .all_bit_clk      (all_bit_clk),
        .control_reg_clk  (control_reg_clk),
        .control_data_ser (control_data_ser),
        .digit_data_ser   (digit_data_ser),
        .frame_out        (frame_out),
        .frame_valid      (frame_valid),
        .len_err          (len_err),
        .sel_err          (sel_err),
        .state            (state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [47:0]     exp_q[$];
    logic [47:0]     last_frame;
    logic [7:0]      m_ctl;
    logic [7:0]      m_dig;
    logic [5:0][7:0] m_staging;
    logic [5:0]      m_seen;

    typedef struct {
        logic [7:0] sel;
        logic [7:0] pins;
        int         nbits;
        logic       exp_len;
        logic       exp_sel;
    } vec_t;

    vec_t tbl[22];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_clear();
        m_ctl     = '0;
        m_dig     = '0;
        m_staging = '0;
        m_seen    = '0;
    endtask

    task automatic model_latch(input int nbits);
        logic ok_len, ok_sel;
        ok_len = (nbits == 8);
        ok_sel = (m_ctl[7:6] == 2'b00) && ($countones(m_ctl[5:0]) == 1);
        if (ok_len && ok_sel) begin
            for (int k = 0; k < 6; k++) begin
                if (m_ctl[k]) begin
                    m_staging[k] = ~m_dig;
                    m_seen[k]    = 1'b1;
                end
            end
            if (&m_seen) begin
                exp_q.push_back(m_staging);
                last_frame = m_staging;
                m_seen     = '0;
            end
        end
    endtask

    task automatic xfer(input logic [7:0] sel, input logic [7:0] pins, input int nbits, input bit same);
        for (int i = nbits - 1; i >= 0; i--) begin
            control_data_ser = sel[i];
            digit_data_ser   = pins[i];
            m_ctl = {m_ctl[6:0], sel[i]};
            m_dig = {m_dig[6:0], pins[i]};
            cycles(4);
            all_bit_clk = 1'b1;
            if (same && i == 0) begin
                control_reg_clk = 1'b1;
                model_latch(nbits);
            end
            cycles(4);
            all_bit_clk     = 1'b0;
            control_reg_clk = 1'b0;
            cycles(4);
        end
        if (!same) begin
            model_latch(nbits);
            control_reg_clk = 1'b1;
            cycles(4);
            control_reg_clk = 1'b0;
            cycles(4);
        end
        cycles(2);
    endtask

    task automatic slot(input int k, input logic [7:0] pins);
        xfer(8'(1 << k), pins, 8, 1'b0);
    endtask

    task automatic check_flags(input logic el, input logic es);
        check("len_err", 64'(len_err), 64'(el));
        check("sel_err", 64'(sel_err), 64'(es));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        all_nrst = 1'b1;
        all_bit_clk = 1'b0;
        control_reg_clk = 1'b0;
        control_data_ser = 1'b0;
        digit_data_ser = 1'b0;
        last_frame = '0;
        model_clear();
        cycles(3);
        check("rst_frame_out", 64'(frame_out), 64'h0);
        check("rst_frame_valid", 64'(frame_valid), 64'h0);
        check_flags(1'b0, 1'b0);
        check("rst_state", 64'(state), 64'(CLEAR));
        rst = 1'b0;
        cycles(8);
        check("state_shift_after_rst", 64'(state), 64'(SHIFT));

        fork
            forever begin
                @(negedge clk);
                if (frame_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame_valid", 64'(frame_out), 64'h0);
                        if (frame_out == '0) begin
                            n_fail++;
                            $display("FAIL unexpected_frame_valid: got pulse expected none");
                        end
                    end else begin
                        check("frame_out", 64'(frame_out), 64'(exp_q.pop_front()));
                    end
                end
            end
        join_none

        tbl[0]  = '{8'h01, ~8'h06, 8, 1'b0, 1'b0};
        tbl[1]  = '{8'h02, ~8'h5B, 8, 1'b0, 1'b0};
        tbl[2]  = '{8'h04, ~8'h4F, 8, 1'b0, 1'b0};
        tbl[3]  = '{8'h08, ~8'h66, 8, 1'b0, 1'b0};
        tbl[4]  = '{8'h10, ~8'h6D, 8, 1'b0, 1'b0};
        tbl[5]  = '{8'h20, ~8'h7D, 8, 1'b0, 1'b0};
        tbl[6]  = '{8'h04, 8'hAA, 8, 1'b0, 1'b0};
        tbl[7]  = '{8'h01, 8'h11, 8, 1'b0, 1'b0};
        tbl[8]  = '{8'h02, 8'h22, 8, 1'b0, 1'b0};
        tbl[9]  = '{8'h04, 8'h55, 8, 1'b0, 1'b0};
        tbl[10] = '{8'h08, 8'h33, 8, 1'b0, 1'b0};
        tbl[11] = '{8'h10, 8'h44, 8, 1'b0, 1'b0};
        tbl[12] = '{8'h20, 8'h77, 8, 1'b0, 1'b0};
        tbl[13] = '{8'h04, 8'hC3, 8, 1'b0, 1'b0};
        tbl[14] = '{8'h08, 8'h3C, 8, 1'b0, 1'b0};
        tbl[15] = '{8'h10, 8'h5A, 8, 1'b0, 1'b0};
        tbl[16] = '{8'h03, 8'hFF, 8, 1'b0, 1'b1};
        tbl[17] = '{8'h40, 8'h0F, 8, 1'b0, 1'b1};
        tbl[18] = '{8'h20, 8'h00, 7, 1'b1, 1'b1};
        tbl[19] = '{8'h20, 8'h81, 8, 1'b1, 1'b1};
        tbl[20] = '{8'h01, 8'hE7, 8, 1'b1, 1'b1};
        tbl[21] = '{8'h02, 8'h18, 8, 1'b1, 1'b1};

        for (int i = 0; i < 22; i++) begin
            xfer(tbl[i].sel, tbl[i].pins, tbl[i].nbits, 1'b0);
            check_flags(tbl[i].exp_len, tbl[i].exp_sel);
            if (i == 5)  check("frame1_digits", 64'(frame_out), 64'h7D6D664F5B06);
            if (i == 12) check("slot2_rewrite", 64'(frame_out[2]), 64'hAA);
        end

        // Final bit of slot 0 arrives in the same cycle as the latch strobe.
        xfer(8'h01, 8'h3E, 8, 1'b1);
        for (int k = 1; k < 6; k++) slot(k, 8'($urandom_range(0, 255)));
        check("same_cycle_slot0", 64'(frame_out[0]), 64'hC1);
        check_flags(1'b1, 1'b1);

        for (int k = 0; k < 3; k++) slot(k, 8'($urandom_range(0, 255)));
        all_nrst = 1'b0;
        cycles(6);
        check("state_in_clear", 64'(state), 64'(CLEAR));
        model_clear();
        all_nrst = 1'b1;
        cycles(6);
        check("frame_retained", 64'(frame_out), 64'(last_frame));
        check("state_after_nrst", 64'(state), 64'(SHIFT));
        check_flags(1'b1, 1'b1);
        for (int k = 3; k < 6; k++) slot(k, 8'($urandom_range(0, 255)));
        check("frame_held_partial", 64'(frame_out), 64'(last_frame));
        for (int k = 0; k < 3; k++) slot(k, 8'($urandom_range(0, 255)));

        for (int i = 0; i < 4; i++) begin
            control_data_ser = 1'b1;
            digit_data_ser   = 1'b1;
            cycles(4);
            all_bit_clk = 1'b1;
            cycles(4);
            all_bit_clk = 1'b0;
            cycles(2);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midshift_rst_frame_out", 64'(frame_out), 64'h0);
        check("midshift_rst_frame_valid", 64'(frame_valid), 64'h0);
        check_flags(1'b0, 1'b0);
        check("midshift_rst_state", 64'(state), 64'(CLEAR));
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        last_frame = '0;
        cycles(8);

        for (int k = 5; k >= 0; k--) slot(k, 8'($urandom_range(0, 255)));
        check_flags(1'b0, 1'b0);
        check("frame_after_rst", 64'(frame_out), 64'(last_frame));

        cycles(10);
        check("frames_pending", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
